// File: rtl/noc_egress_deframer_pkg.sv
// Shared definitions for the NoC egress deframer.
// Holds the parser state encoding, the header field positions and a
// checksum helper used by the top level.
package noc_egress_deframer_pkg;

    typedef enum logic [1:0] {
        ST_HDR     = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CSUM    = 2'd2
    } state_e;

    localparam int DEST_MSB = 7;
    localparam int DEST_LSB = 6;
    localparam int LEN_MSB  = 5;
    localparam int LEN_LSB  = 0;
    localparam int MAX_LEN  = 63;

    // The packet checksum is the plain byte sum of the payload, modulo 256.
    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction

endpackage

// File: rtl/egress_fifo.sv
// First-word-fall-through payload FIFO for the egress deframer.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset (flushes the FIFO)
//   push, push_data write one entry; ignored when full
//   pop             remove the head entry; ignored when empty
//   pop_data        current head entry, zero while empty
//   full, empty     occupancy flags
//   level           number of stored entries (0..DEPTH)
module egress_fifo #(
    parameter int DEPTH      = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_WIDTH-1:0]    push_data,
    input  logic                     pop,
    output logic [DATA_WIDTH-1:0]    pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  do_push;
    logic                  do_pop;

    // Pointers carry one extra wrap bit: equal pointers mean empty, pointers
    // that differ only in the wrap bit mean full.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = wr_ptr_q - rd_ptr_q;

    // The head is shown combinationally so a pushed byte appears on the very
    // next cycle; it reads as zero while the FIFO holds nothing.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    // Advance each pointer by one on an accepted push or pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
    end

    // Reset flushes the FIFO by realigning both pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: stale entries are never visible because the
    // head output is gated by the empty flag.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/noc_egress_deframer.sv
// Egress end of the NoC byte stream. Parses header / payload / checksum
// packets, buffers payload of packets addressed to PORT_ID in a FWFT FIFO
// and silently consumes packets addressed elsewhere.
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   in_data, in_valid, in_ready    byte stream from the last NoC switch
//   out_data, out_valid, out_ready payload stream towards the pins
//   clr_err                        synchronous clear of csum_err
//   pkt_done                       pulse on the checksum byte of a matching packet
//   csum_err                       sticky checksum mismatch flag
//   pkt_cnt                        matching packets completed, wrapping
//   fifo_level                     payload FIFO occupancy
module noc_egress_deframer
    import noc_egress_deframer_pkg::*;
#(
    parameter logic [1:0] PORT_ID    = 2'd0,
    parameter int         DEPTH      = 4,
    parameter int         DATA_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    input  logic                   clr_err,
    output logic                   pkt_done,
    output logic                   csum_err,
    output logic [7:0]             pkt_cnt,
    output logic [$clog2(DEPTH):0] fifo_level
);

    localparam int LW = LEN_MSB - LEN_LSB + 1;

    state_e          state_q, state_d;
    logic            match_q, match_d;
    logic [LW-1:0]   len_q, len_d;
    logic [LW-1:0]   cnt_q, cnt_d;
    logic [7:0]      sum_q, sum_d;
    logic [7:0]      pkt_cnt_q, pkt_cnt_d;
    logic            csum_err_q, csum_err_d;
    logic            xfer;
    logic            fifo_push;
    logic            fifo_full;
    logic            fifo_empty;

    egress_fifo #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (in_data),
        .pop       (out_ready),
        .pop_data  (out_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // Only matching payload can stall the stream, and only on a FIFO that is
    // full before any same-cycle pop. Ready is held low throughout reset.
    always_comb begin
        in_ready = rst_n;
        if (state_q == ST_PAYLOAD && match_q && fifo_full) begin
            in_ready = 1'b0;
        end
    end

    assign xfer      = in_valid && in_ready;
    assign fifo_push = xfer && (state_q == ST_PAYLOAD) && match_q;
    assign pkt_done  = xfer && (state_q == ST_CSUM) && match_q;
    assign out_valid = !fifo_empty;
    assign csum_err  = csum_err_q;
    assign pkt_cnt   = pkt_cnt_q;

    // Packet parser. The error flag is cleared first so that a mismatch in
    // the same cycle as clr_err still leaves it set.
    always_comb begin
        state_d    = state_q;
        match_d    = match_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        pkt_cnt_d  = pkt_cnt_q;
        csum_err_d = clr_err ? 1'b0 : csum_err_q;
        case (state_q)
            ST_HDR: begin
                if (xfer) begin
                    match_d = (in_data[DEST_MSB:DEST_LSB] == PORT_ID);
                    len_d   = in_data[LEN_MSB:LEN_LSB];
                    sum_d   = '0;
                    cnt_d   = '0;
                    state_d = (in_data[LEN_MSB:LEN_LSB] != '0) ? ST_PAYLOAD : ST_CSUM;
                end
            end
            ST_PAYLOAD: begin
                if (xfer) begin
                    sum_d = csum_add(sum_q, in_data);
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == len_q) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    state_d = ST_HDR;
                    if (match_q) begin
                        pkt_cnt_d = pkt_cnt_q + 8'd1;
                        if (in_data != sum_q) begin
                            csum_err_d = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_HDR;
            end
        endcase
    end

    // Parser state; a reset mid-packet drops the partial packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_HDR;
            match_q    <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            sum_q      <= '0;
            pkt_cnt_q  <= '0;
            csum_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            match_q    <= match_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            sum_q      <= sum_d;
            pkt_cnt_q  <= pkt_cnt_d;
            csum_err_q <= csum_err_d;
        end
    end

endmodule
